// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   - Register offsets, decoded from Addr[4:2]
//   - FSM state encoding
//   - CUR_ID valid-bit position
//   - lowest_set(): index of the lowest set bit (fixed priority, index 0 highest)
package interrupt_controller_pkg;

   localparam logic [2:0] RegPend  = 3'd0;
   localparam logic [2:0] RegMask  = 3'd1;
   localparam logic [2:0] RegCtrl  = 3'd2;
   localparam logic [2:0] RegCurId = 3'd3;
   localparam logic [2:0] RegEoi   = 3'd4;

   localparam int unsigned CurIdValidBit = 31;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StSvc  = 2'd2
   } ic_state_e;

   // Scan from the top so that the last hit, the lowest index, wins.
   function automatic logic [4:0] lowest_set(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/interrupt_controller_irq_sync_edge.sv
// Synchronizer plus rising-edge detector for one interrupt source.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-low reset
//   din    in  asynchronous level input
//   pulse  out one-cycle pulse, high for the cycle after a synchronized 0->1 transition
module irq_sync_edge #(
   parameter int unsigned SYNC_FF = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic [SYNC_FF-1:0] sync_q;
   logic               prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_FF-2:0], din};
         prev_q <= sync_q[SYNC_FF-1];
      end
   end

   // A level that stays high produces a single pulse only.
   assign pulse = sync_q[SYNC_FF-1] & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller feeding Control_Unit.
// Collects rising edges on irq_src into PEND, requests service via intr, completes the
// intr/int_ack handshake and exposes the serviced source in CUR_ID until software writes EOI.
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   irq_src[NUM_SRC]      asynchronous edge-triggered requests
//   Addr, D_in            bus address (bits [4:2] select register) and write data
//   io_cs, io_wr, io_rd   chip select and strobes
//   D_out                 combinational read data, 0 when not selected for read
//   intr                  registered request to Control_Unit
//   int_ack               one-cycle acknowledge from Control_Unit
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned SYNC_FF = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [11:0]        Addr,
   input  logic [31:0]        D_in,
   input  logic               io_cs,
   input  logic               io_wr,
   input  logic               io_rd,
   output logic [31:0]        D_out,
   output logic               intr,
   input  logic               int_ack
);

   logic [NUM_SRC-1:0] edge_pulse;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] eligible, w1c, ack_clr;
   logic               gie_q, gie_d;
   logic               intr_q, intr_d;
   logic               cur_valid_q, cur_valid_d;
   logic [4:0]         cur_sel_q, cur_sel_d;
   ic_state_e          state_q, state_d;

   logic [2:0]  reg_sel;
   logic        wr_en, rd_en, eoi_wr, ack_take;
   logic [31:0] elig_ext;
   logic [4:0]  sel;
   logic        unused_bus;

   assign reg_sel    = Addr[4:2];
   assign wr_en      = io_cs & io_wr;
   assign rd_en      = io_cs & io_rd;
   assign eoi_wr     = wr_en && (reg_sel == RegEoi);
   assign unused_bus = ^{Addr[11:5], Addr[1:0], D_in};

   for (genvar g = 0; g < NUM_SRC; g++) begin : gen_sync
      irq_sync_edge #(
         .SYNC_FF(SYNC_FF)
      ) u_sync (
         .clk  (clk),
         .rst  (rst),
         .din  (irq_src[g]),
         .pulse(edge_pulse[g])
      );
   end

   assign eligible = pend_q & ~mask_q & {NUM_SRC{gie_q}};

   always_comb begin
      elig_ext = '0;
      elig_ext[NUM_SRC-1:0] = eligible;
   end

   assign sel = lowest_set(elig_ext);

   // FSM: intr is high exactly while in StReq.
   always_comb begin
      state_d  = state_q;
      intr_d   = 1'b0;
      ack_take = 1'b0;
      case (state_q)
         StIdle: begin
            if (|eligible) begin
               state_d = StReq;
               intr_d  = 1'b1;
            end
         end
         StReq: begin
            if (!(|eligible)) begin
               state_d = StIdle;
            end else if (int_ack) begin
               state_d  = StSvc;
               ack_take = 1'b1;
            end else begin
               intr_d = 1'b1;
            end
         end
         StSvc: begin
            if (eoi_wr) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Register next-state. A new edge wins over both W1C and the ack clear.
   always_comb begin
      w1c = '0;
      if (wr_en && (reg_sel == RegPend)) w1c = D_in[NUM_SRC-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = ack_take && (sel == 5'(i));
      end
      pend_d = (pend_q & ~w1c & ~ack_clr) | edge_pulse;

      mask_d = mask_q;
      if (wr_en && (reg_sel == RegMask)) mask_d = D_in[NUM_SRC-1:0];

      gie_d = gie_q;
      if (wr_en && (reg_sel == RegCtrl)) gie_d = D_in[0];

      cur_valid_d = cur_valid_q;
      cur_sel_d   = cur_sel_q;
      if (ack_take) begin
         cur_valid_d = 1'b1;
         cur_sel_d   = sel;
      end else if ((state_q == StSvc) && eoi_wr) begin
         cur_valid_d = 1'b0;
         cur_sel_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         intr_q      <= 1'b0;
         pend_q      <= '0;
         mask_q      <= '1;
         gie_q       <= 1'b0;
         cur_valid_q <= 1'b0;
         cur_sel_q   <= '0;
      end else begin
         state_q     <= state_d;
         intr_q      <= intr_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         gie_q       <= gie_d;
         cur_valid_q <= cur_valid_d;
         cur_sel_q   <= cur_sel_d;
      end
   end

   assign intr = intr_q;

   always_comb begin
      D_out = '0;
      if (rd_en) begin
         case (reg_sel)
            RegPend:  D_out[NUM_SRC-1:0] = pend_q;
            RegMask:  D_out[NUM_SRC-1:0] = mask_q;
            RegCtrl:  D_out[0] = gie_q;
            RegCurId: begin
               D_out[CurIdValidBit] = cur_valid_q;
               D_out[4:0]           = cur_sel_q;
            end
            default: D_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of the register file and request/service protocol.
module tb_interrupt_controller;

   localparam int unsigned NSRC     = 8;
   localparam int unsigned SFF      = 2;
   localparam logic [31:0] SRC_MASK = 32'h0000_00FF;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] irq_src;
   logic [11:0]     Addr;
   logic [31:0]     D_in;
   logic            io_cs, io_wr, io_rd;
   logic [31:0]     D_out;
   logic            intr;
   logic            int_ack;
   logic [2:0]      r;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   interrupt_controller #(
      .NUM_SRC(NSRC),
      .SYNC_FF(SFF)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_src(irq_src),
      .Addr   (Addr),
      .D_in   (D_in),
      .io_cs  (io_cs),
      .io_wr  (io_wr),
      .io_rd  (io_rd),
      .D_out  (D_out),
      .intr   (intr),
      .int_ack(int_ack)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0]     m_pend, m_mask, m_cur;
   bit              m_gie, m_req, m_svc;
   logic [NSRC-1:0] hist[$];   // raw samples of irq_src, one per clock

   function automatic void model_reset();
      m_pend = '0;
      m_mask = SRC_MASK;
      m_gie  = 1'b0;
      m_cur  = '0;
      m_req  = 1'b0;
      m_svc  = 1'b0;
      hist.delete();
      for (int i = 0; i <= int'(SFF); i++) hist.push_back('0);
   endfunction

   // Effect of one rising clock edge given the inputs currently applied.
   function automatic void model_step();
      logic [31:0] elig, edges, nxt;
      bit          wr;
      int          sel;
      hist.push_back(irq_src);
      // A sample taken at edge n shows up in PEND at edge n+SFF.
      edges = 32'(hist[1] & ~hist[0]);
      void'(hist.pop_front());
      elig = m_gie ? (m_pend & ~m_mask) : 32'd0;
      wr   = io_cs && io_wr;
      nxt  = m_pend;
      if (wr && Addr[4:2] == 3'd0) nxt = nxt & ~D_in;
      if (m_req) begin
         m_req = 1'b0;
         if (elig != 0 && int_ack) begin
            sel = 0;
            for (int i = 0; i < int'(NSRC); i++) begin
               if (elig[i]) begin
                  sel = i;
                  break;
               end
            end
            m_cur     = 32'h8000_0000 | 32'(sel);
            nxt[sel]  = 1'b0;
            m_svc     = 1'b1;
         end else if (elig != 0) begin
            m_req = 1'b1;
         end
      end else if (m_svc) begin
         if (wr && Addr[4:2] == 3'd4) begin
            m_svc = 1'b0;
            m_cur = '0;
         end
      end else if (elig != 0) begin
         m_req = 1'b1;
      end
      m_pend = (nxt | edges) & SRC_MASK;
      if (wr && Addr[4:2] == 3'd1) m_mask = D_in & SRC_MASK;
      if (wr && Addr[4:2] == 3'd2) m_gie = D_in[0];
   endfunction

   function automatic logic [31:0] model_rd();
      if (!(io_cs && io_rd)) return '0;
      case (Addr[4:2])
         3'd0:    return m_pend;
         3'd1:    return m_mask;
         3'd2:    return {31'd0, m_gie};
         3'd3:    return m_cur;
         default: return '0;
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   // Called just after a rising edge; checks mid-cycle, then advances one clock.
   task automatic tick(input bit chk = 1'b0, input logic [31:0] exp = '0,
                       input string tag = "");
      @(negedge clk);
      check_val("intr", 32'(intr), 32'(m_req));
      check_val("d_out", D_out, model_rd());
      if (chk) check_val(tag, D_out, exp);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
      Addr = '0; D_in = '0; int_ack = 1'b0;
   endtask

   task automatic wr_reg(input logic [2:0] rg, input logic [31:0] data);
      io_cs = 1'b1; io_wr = 1'b1; Addr = {7'd0, rg, 2'b00}; D_in = data;
      tick();
      bus_idle();
   endtask

   task automatic rd_reg(input logic [2:0] rg, input logic [31:0] exp, input string tag);
      io_cs = 1'b1; io_rd = 1'b1; Addr = {7'd0, rg, 2'b00};
      tick(1'b1, exp, tag);
      bus_idle();
   endtask

   task automatic do_ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic pulse_src(input logic [NSRC-1:0] bits);
      irq_src = irq_src | bits;
      tick();
      irq_src = irq_src & ~bits;
   endtask

   task automatic expect_intr(input bit e, input string tag);
      check_val(tag, 32'(intr), 32'(e));
   endtask

   initial begin
      rst = 1'b0;
      irq_src = '0;
      bus_idle();
      model_reset();

      // 1: reset held with toggling sources
      #2;
      for (int i = 0; i < 4; i++) begin
         irq_src = NSRC'($urandom);
         io_cs = 1'b1; io_rd = 1'b1;
         Addr = (i % 2 == 0) ? 12'h004 : 12'h000;
         @(negedge clk);
         check_val("rst_intr", 32'(intr), 32'd0);
         check_val((i % 2 == 0) ? "rst_mask" : "rst_pend", D_out,
                   (i % 2 == 0) ? SRC_MASK : 32'd0);
         @(posedge clk);
         #1;
      end
      irq_src = '0;
      bus_idle();
      rst = 1'b1;
      model_reset();

      // 2: basic handshake on source 3
      wr_reg(3'd1, 32'd0);
      wr_reg(3'd2, 32'd1);
      pulse_src(8'h08);
      tick();
      tick();
      rd_reg(3'd0, 32'h08, "t2_pend");
      expect_intr(1'b1, "t2_intr_req");
      do_ack();
      expect_intr(1'b0, "t2_intr_ack");
      rd_reg(3'd3, 32'h8000_0003, "t2_cur");
      rd_reg(3'd0, 32'h0, "t2_pend_clr");
      wr_reg(3'd4, 32'd0);
      rd_reg(3'd3, 32'h0, "t2_cur_eoi");

      // 3: fixed priority
      pulse_src(8'h24);
      tick();
      tick();
      tick();
      expect_intr(1'b1, "t3_intr");
      do_ack();
      rd_reg(3'd3, 32'h8000_0002, "t3_cur2");
      rd_reg(3'd0, 32'h20, "t3_pend");
      wr_reg(3'd4, 32'd0);
      tick();
      expect_intr(1'b1, "t3_reintr");
      do_ack();
      rd_reg(3'd3, 32'h8000_0005, "t3_cur5");
      wr_reg(3'd4, 32'd0);

      // 4: mask withdraws a pending request
      pulse_src(8'h02);
      tick();
      tick();
      tick();
      expect_intr(1'b1, "t4_intr");
      wr_reg(3'd1, 32'h02);
      tick();
      expect_intr(1'b0, "t4_withdrawn");
      rd_reg(3'd0, 32'h02, "t4_pend");
      wr_reg(3'd1, 32'h00);
      tick();
      expect_intr(1'b1, "t4_reintr");
      do_ack();
      wr_reg(3'd4, 32'd0);

      // 5: set/clear collision, acks outside REQ
      pulse_src(8'h10);
      tick();
      io_cs = 1'b1; io_wr = 1'b1; Addr = 12'h000; D_in = 32'h10; int_ack = 1'b1;
      tick();
      bus_idle();
      expect_intr(1'b0, "t5_idle_ack");
      rd_reg(3'd0, 32'h10, "t5_pend");
      expect_intr(1'b1, "t5_intr");
      do_ack();
      do_ack();
      expect_intr(1'b0, "t5_svc_ack");
      rd_reg(3'd3, 32'h8000_0004, "t5_cur");
      wr_reg(3'd4, 32'd0);

      // 6: asynchronous reset during service
      pulse_src(8'h40);
      tick();
      tick();
      tick();
      do_ack();
      io_cs = 1'b1; io_rd = 1'b1; Addr = 12'h00C;
      #1;
      check_val("t6_cur_pre", D_out, 32'h8000_0006);
      #1;
      rst = 1'b0;
      #1;
      check_val("t6_intr", 32'(intr), 32'd0);
      check_val("t6_cur", D_out, 32'h0);
      Addr = 12'h004;
      #1;
      check_val("t6_mask", D_out, SRC_MASK);
      bus_idle();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) irq_src = irq_src ^ NSRC'($urandom);
         io_cs   = 1'($urandom_range(0, 1));
         io_wr   = ($urandom_range(0, 2) == 0);
         io_rd   = 1'($urandom_range(0, 1));
         r       = 3'($urandom_range(0, 7));
         Addr    = {7'($urandom), r, 2'($urandom)};
         D_in    = $urandom & $urandom;
         if (r == 3'd2) D_in[0] = ($urandom_range(0, 3) != 0);
         int_ack = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
